lfu_alloc_ctrl: RTL

LFU_ALLOC_CTRL -- requirements
Module: lfu_alloc_ctrl

---
 rtl/lfu_pkg.sv | 6 +
 rtl/lfu_cnt_bank.sv | 30 +++
 rtl/lfu_alloc_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/lfu_pkg.sv
// lfu_pkg: shared types and sizes for the LFU replacement allocator.
package lfu_pkg;
  localparam int NUM_BUF   = 4;
  localparam int BUF_IDX_W = 2;
  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_e;
endpackage

// File: rtl/lfu_cnt_bank.sv
// lfu_cnt_bank: per-buffer saturating access counters with halving aging and grant reset.
module lfu_cnt_bank
  import lfu_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ref_vld_i,
  input  logic [BUF_IDX_W-1:0]               ref_buf_i,
  input  logic                               clr_vld_i,
  input  logic [BUF_IDX_W-1:0]               clr_buf_i,
  output logic [NUM_BUF-1:0][CNT_W-1:0]      cnt_o
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [NUM_BUF-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic hit, sat;
  // A reference to the buffer being granted is dropped; that counter is forced to 1.
  always_comb begin
    hit = ref_vld_i && !(clr_vld_i && ref_buf_i == clr_buf_i);
    sat = hit && cnt_q[ref_buf_i] == MAX;
    for (int i = 0; i < NUM_BUF; i++)
      cnt_d[i] = (clr_vld_i && clr_buf_i == BUF_IDX_W'(i)) ? CNT_W'(1) :
                 (sat ? cnt_q[i] >> 1 : cnt_q[i]) + CNT_W'(hit && ref_buf_i == BUF_IDX_W'(i));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= {NUM_BUF{CNT_W'(1)}};
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/lfu_alloc_ctrl.sv
// lfu_alloc_ctrl: snapshots LFU counters on request, scans for the minimum, grants the winner.
module lfu_alloc_ctrl
  import lfu_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ref_vld,
  input  logic [BUF_IDX_W-1:0] ref_buf_numbr,
  input  logic                 alloc_req,
  output logic                 alloc_ack,
  output logic [BUF_IDX_W-1:0] alloc_buf,
  output logic                 busy,
  output logic [BUF_IDX_W-1:0] lfu_buf
);
  localparam logic [BUF_IDX_W:0] SCAN_END = (BUF_IDX_W+1)'(NUM_BUF);
  state_e                        state_q;
  logic [NUM_BUF-1:0][CNT_W-1:0] cnt, snap_q;
  logic [BUF_IDX_W:0]            idx_q;
  logic [CNT_W-1:0]              min_q, lo;
  logic [BUF_IDX_W-1:0]          win_q;
  lfu_cnt_bank #(.CNT_W(CNT_W)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_vld_i (ref_vld),
    .ref_buf_i (ref_buf_numbr),
    .clr_vld_i (state_q == GRANT),
    .clr_buf_i (alloc_buf),
    .cnt_o     (cnt)
  );
  always_comb begin
    lo = cnt[0];
    lfu_buf = '0;
    for (int i = 1; i < NUM_BUF; i++)
      if (cnt[i] < lo) begin
        lo = cnt[i];
        lfu_buf = BUF_IDX_W'(i);
      end
  end
  // idx_q steps 0..3 comparing snapshots; the idx_q==NUM_BUF cycle hands the settled winner to GRANT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      min_q     <= '0;
      win_q     <= '0;
      alloc_ack <= 1'b0;
      alloc_buf <= '0;
      busy      <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (alloc_req) begin
            state_q <= SCAN;
            snap_q  <= cnt;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        SCAN:
          if (!alloc_req) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (idx_q == SCAN_END) begin
            state_q   <= GRANT;
            alloc_ack <= 1'b1;
            alloc_buf <= win_q;
          end else begin
            if (idx_q == '0 || snap_q[idx_q[BUF_IDX_W-1:0]] < min_q) begin
              min_q <= snap_q[idx_q[BUF_IDX_W-1:0]];
              win_q <= idx_q[BUF_IDX_W-1:0];
            end
            idx_q <= idx_q + (BUF_IDX_W+1)'(1);
          end
        GRANT: begin
          state_q   <= IDLE;
          alloc_ack <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
endmodule
